// File: rtl/ram_sdp_param.sv
// Simple-dual-port synchronous RAM with byte write enables, a 1- or 2-stage
// read pipeline, selectable read-during-write result and a clear engine
// that zeroes the whole array after reset or on a clr pulse.

// One byte lane of the array: a single write port and an asynchronous read
// tap. Forwarding of same-address write data is chosen by the parent via fwd.
module ram_sdp_param_lane #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              fwd,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];

    // Storage has no reset; the clear engine writes zeros through this port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = fwd ? wdata : mem[raddr];
endmodule

module ram_sdp_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int RD_LAT   = 1,   // 1 or 2
    parameter int RDW_MODE = 0    // 0 = old data, 1 = new (byte-merged) data
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                busy,
    input  logic                w_en,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_be,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int STAGES    = RD_LAT;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
    logic              clearing;
    logic              wr_acc, rd_acc;

    logic [NUM_LANES-1:0]       mem_we;
    logic [NUM_LANES-1:0][7:0]  mem_wdata;
    logic [NUM_LANES-1:0][7:0]  lane_rd;
    logic [NUM_LANES-1:0]       lane_fwd;
    logic [ADDR_W-1:0]          mem_waddr;
    logic [DATA_W-1:0]          rd_word;

    logic [STAGES:0]              vld_pipe;
    logic [STAGES-1:0]            vld_q;
    logic [STAGES:0][DATA_W-1:0]  d_pipe;
    logic [STAGES-1:0][DATA_W-1:0] d_q;

    // Clear engine state register; reset lands in CLEAR so the array is swept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nx;
            clr_ptr <= clr_ptr_nx;
        end
    end

    // Next-state: sweep every address once, then idle until the next clr.
    // clr while sweeping is ignored so the sweep is never restarted.
    always_comb begin
        state_nx   = state;
        clr_ptr_nx = clr_ptr;
        case (state)
            CLEAR: begin
                clr_ptr_nx = clr_ptr + 1'b1;
                if (clr_ptr == '1) state_nx = IDLE;
            end
            IDLE: begin
                if (clr) begin
                    state_nx   = CLEAR;
                    clr_ptr_nx = '0;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    assign clearing = (state == CLEAR);
    assign busy     = clearing;
    // clr outranks accesses issued in the same cycle.
    assign wr_acc   = !clearing && !clr && w_en;
    assign rd_acc   = !clearing && !clr && r_en;

    assign mem_waddr = clearing ? clr_ptr : w_addr;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            assign mem_we[i]    = clearing || (wr_acc && w_be[i]);
            assign mem_wdata[i] = clearing ? 8'h00 : w_data[8*i +: 8];
            // Forward only enabled bytes of a same-address write, giving the
            // byte-merged word in new-data mode.
            assign lane_fwd[i]  = (RDW_MODE == 1) && wr_acc && w_be[i]
                                  && (r_addr == w_addr);

            ram_sdp_param_lane #(.ADDR_W(ADDR_W)) u_lane (
                .clk   (clk),
                .we    (mem_we[i]),
                .waddr (mem_waddr),
                .wdata (mem_wdata[i]),
                .raddr (r_addr),
                .fwd   (lane_fwd[i]),
                .rdata (lane_rd[i])
            );
        end
    endgenerate

    assign rd_word  = lane_rd;
    assign vld_pipe = {vld_q, rd_acc};
    assign d_pipe   = {d_q, rd_word};

    // Read pipeline: valid shifts every cycle; data stages load only with a
    // valid entry so r_data holds between reads. In-flight entries drain even
    // when a clear starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            d_q   <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            for (int k = 0; k < STAGES; k++) begin
                if (vld_pipe[k]) d_q[k] <= d_pipe[k];
            end
        end
    end

    assign r_valid = vld_pipe[STAGES];
    assign r_data  = d_pipe[STAGES];
endmodule

// File: tb/tb_ram_sdp_param.sv
// Directed bench for ram_sdp_param. Three instances share one stimulus:
// u1 = RD_LAT 1 / old-data, u2 = RD_LAT 2 / old-data, u3 = RD_LAT 1 / new-data.
module tb_ram_sdp_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        w_en = 1'b0;
    logic [3:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic [1:0]  w_be = '0;
    logic        r_en = 1'b0;
    logic [3:0]  r_addr = '0;

    logic        busy1, busy2, busy3;
    logic [15:0] r_data1, r_data2, r_data3;
    logic        r_valid1, r_valid2, r_valid3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_sdp_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy1),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data1), .r_valid(r_valid1));
    ram_sdp_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(0)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy2),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data2), .r_valid(r_valid2));
    ram_sdp_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(1)) u3 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy3),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data3), .r_valid(r_valid3));

    // One-cycle write.
    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        @(negedge clk);
        w_en = 1'b1; w_addr = a; w_data = d; w_be = be;
        @(negedge clk);
        w_en = 1'b0; w_be = '0;
    endtask

    // One-cycle read; captures latency-1 outputs after the accept edge and
    // latency-2 outputs one edge later (v1b = u1 valid at that later point).
    task automatic rd(input logic [3:0] a,
                      output logic [15:0] d1, output logic [15:0] d2, output logic [15:0] d3,
                      output logic v1, output logic v2, output logic v3, output logic v1b);
        @(negedge clk);
        r_en = 1'b1; r_addr = a;
        @(posedge clk); #1;
        d1 = r_data1; v1 = r_valid1; d3 = r_data3; v3 = r_valid3;
        @(negedge clk);
        r_en = 1'b0;
        @(posedge clk); #1;
        d2 = r_data2; v2 = r_valid2; v1b = r_valid1;
    endtask

    // Counts the cycles busy is high (sampled mid-cycle) until it falls,
    // injecting a stray read and a stray clr while the sweep runs.
    // Caller is positioned at a negedge. Bounded to 48 cycles.
    task automatic count_busy(output int n1, output int n2, output int n3, output logic anyv);
        logic seen;
        n1 = 0; n2 = 0; n3 = 0; anyv = 1'b0; seen = 1'b0;
        for (int k = 0; k < 48; k++) begin
            if (busy1) n1++;
            if (busy2) n2++;
            if (busy3) n3++;
            if (busy1 || busy2 || busy3) seen = 1'b1;
            else if (seen) break;
            @(posedge clk); #1;
            if (r_valid1 || r_valid2 || r_valid3) anyv = 1'b1;
            @(negedge clk);
            clr = (k == 3); w_en = 1'b0; r_en = (k == 1); r_addr = 4'd7;
        end
        clr = 1'b0; r_en = 1'b0;
    endtask

    task automatic test_reset;
        int n1, n2, n3;
        logic anyv, v1, v2, v3, v1b;
        logic [15:0] d1, d2, d3;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r_data1, r_data2, r_data3} !== 48'h0 || {r_valid1, r_valid2, r_valid3} !== 3'b000
            || {busy1, busy2, busy3} !== 3'b111) begin
            errors++;
            $display("FAIL reset_state: got data %h/%h/%h valid %b%b%b busy %b%b%b expected 0/0/0 000 111",
                     r_data1, r_data2, r_data3, r_valid1, r_valid2, r_valid3, busy1, busy2, busy3);
        end
        rst = 1'b0;
        count_busy(n1, n2, n3, anyv);
        checks++;
        if (n1 !== 16 || n2 !== 16 || n3 !== 16) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d/%0d/%0d expected 16", n1, n2, n3);
        end
        checks++;
        if (anyv !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_valid: got r_valid during sweep, expected none");
        end
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d1, d2, d3, v1, v2, v3, v1b);
            checks++;
            if (d1 !== 16'h0 || d2 !== 16'h0 || d3 !== 16'h0 || {v1, v2, v3, v1b} !== 4'b1110) begin
                errors++;
                $display("FAIL reset_read_zero a=%0d: got %h/%h/%h valid %b%b%b%b expected 0000 valid 1110",
                         a, d1, d2, d3, v1, v2, v3, v1b);
            end
        end
    endtask

    task automatic test_byte_enable;
        logic v1, v2, v3, v1b;
        logic [15:0] d1, d2, d3;
        wr(4'd3, 16'hA5C3, 2'b11);
        wr(4'd3, 16'h1F00, 2'b10);
        rd(4'd3, d1, d2, d3, v1, v2, v3, v1b);
        checks++;
        if (d1 !== 16'h1FC3 || d2 !== 16'h1FC3 || d3 !== 16'h1FC3 || {v1, v2, v3} !== 3'b111) begin
            errors++;
            $display("FAIL byte_enable: got %h/%h/%h valid %b%b%b expected 1FC3 valid 111",
                     d1, d2, d3, v1, v2, v3);
        end
        wr(4'd3, 16'hFFFF, 2'b00);
        rd(4'd3, d1, d2, d3, v1, v2, v3, v1b);
        checks++;
        if (d1 !== 16'h1FC3 || d2 !== 16'h1FC3 || d3 !== 16'h1FC3) begin
            errors++;
            $display("FAIL be_zero_no_write: got %h/%h/%h expected 1FC3", d1, d2, d3);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_d [3] = '{16'h0011, 16'h0022, 16'h0033};
        logic [15:0] d1 [6];
        logic [15:0] d2 [6];
        logic        v1 [6];
        logic        v2 [6];
        logic        ev1, ev2;
        wr(4'd0, 16'h0011, 2'b11);
        wr(4'd1, 16'h0022, 2'b11);
        wr(4'd2, 16'h0033, 2'b11);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            r_en = (k < 3); r_addr = 4'(k);
            @(posedge clk); #1;
            d1[k] = r_data1; v1[k] = r_valid1; d2[k] = r_data2; v2[k] = r_valid2;
        end
        @(negedge clk);
        r_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ev1 = (k < 3);
            ev2 = (k >= 1 && k <= 3);
            checks++;
            if (v1[k] !== ev1 || (k < 3 && d1[k] !== exp_d[k]) || (k >= 3 && d1[k] !== 16'h0033)) begin
                errors++;
                $display("FAIL b2b_lat1 k=%0d: got %h valid %b expected %h valid %b",
                         k, d1[k], v1[k], (k < 3) ? exp_d[k] : 16'h0033, ev1);
            end
            checks++;
            if (v2[k] !== ev2 || (k >= 1 && k <= 3 && d2[k] !== exp_d[k-1])
                || (k >= 4 && d2[k] !== 16'h0033)) begin
                errors++;
                $display("FAIL b2b_lat2 k=%0d: got %h valid %b expected valid %b", k, d2[k], v2[k], ev2);
            end
        end
    endtask

    task automatic test_rdw;
        logic v1, v2, v3, v1b;
        logic [15:0] d1, d2, d3;
        wr(4'd5, 16'h1234, 2'b11);
        @(negedge clk);
        w_en = 1'b1; w_addr = 4'd5; w_data = 16'hBEEF; w_be = 2'b01;
        r_en = 1'b1; r_addr = 4'd5;
        @(posedge clk); #1;
        checks++;
        if (r_data1 !== 16'h1234 || r_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL rdw_old_lat1: got %h valid %b expected 1234 valid 1", r_data1, r_valid1);
        end
        checks++;
        if (r_data3 !== 16'h12EF || r_valid3 !== 1'b1) begin
            errors++;
            $display("FAIL rdw_new: got %h valid %b expected 12EF valid 1", r_data3, r_valid3);
        end
        @(negedge clk);
        w_en = 1'b0; w_be = '0; r_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (r_data2 !== 16'h1234 || r_valid2 !== 1'b1) begin
            errors++;
            $display("FAIL rdw_old_lat2: got %h valid %b expected 1234 valid 1", r_data2, r_valid2);
        end
        rd(4'd5, d1, d2, d3, v1, v2, v3, v1b);
        checks++;
        if (d1 !== 16'h12EF || d2 !== 16'h12EF || d3 !== 16'h12EF) begin
            errors++;
            $display("FAIL rdw_after: got %h/%h/%h expected 12EF", d1, d2, d3);
        end
        // Write and read of different addresses in the same cycle.
        @(negedge clk);
        w_en = 1'b1; w_addr = 4'd6; w_data = 16'hABCD; w_be = 2'b11;
        r_en = 1'b1; r_addr = 4'd5;
        @(posedge clk); #1;
        checks++;
        if (r_data1 !== 16'h12EF || r_data3 !== 16'h12EF) begin
            errors++;
            $display("FAIL diff_addr_read: got %h/%h expected 12EF", r_data1, r_data3);
        end
        @(negedge clk);
        w_en = 1'b0; w_be = '0; r_en = 1'b0;
        rd(4'd6, d1, d2, d3, v1, v2, v3, v1b);
        checks++;
        if (d1 !== 16'hABCD || d2 !== 16'hABCD || d3 !== 16'hABCD) begin
            errors++;
            $display("FAIL diff_addr_write: got %h/%h/%h expected ABCD", d1, d2, d3);
        end
    endtask

    task automatic test_clear;
        int n1, n2, n3;
        logic anyv, v1, v2, v3, v1b;
        logic [15:0] d1, d2, d3;
        wr(4'd7, 16'h7777, 2'b11);
        rd(4'd7, d1, d2, d3, v1, v2, v3, v1b);
        checks++;
        if (d1 !== 16'h7777 || d2 !== 16'h7777 || d3 !== 16'h7777) begin
            errors++;
            $display("FAIL clear_preload: got %h/%h/%h expected 7777", d1, d2, d3);
        end
        @(negedge clk);
        clr = 1'b1; w_en = 1'b1; w_addr = 4'd7; w_data = 16'hFFFF; w_be = 2'b11;
        count_busy(n1, n2, n3, anyv);
        w_be = '0;
        checks++;
        if (n1 !== 16 || n2 !== 16 || n3 !== 16) begin
            errors++;
            $display("FAIL clear_busy_len: got %0d/%0d/%0d expected 16", n1, n2, n3);
        end
        checks++;
        if (anyv !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_valid: got r_valid during busy, expected none");
        end
        rd(4'd7, d1, d2, d3, v1, v2, v3, v1b);
        checks++;
        if (d1 !== 16'h0 || d2 !== 16'h0 || d3 !== 16'h0 || {v1, v2, v3} !== 3'b111) begin
            errors++;
            $display("FAIL clear_read_zero: got %h/%h/%h valid %b%b%b expected 0000 valid 111",
                     d1, d2, d3, v1, v2, v3);
        end
    endtask

    task automatic test_rst_mid_clear;
        int n1, n2, n3;
        logic anyv, v1, v2, v3, v1b;
        logic [15:0] d1, d2, d3;
        wr(4'd15, 16'hDEAD, 2'b11);
        rd(4'd15, d1, d2, d3, v1, v2, v3, v1b);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r_data1, r_data2, r_data3} !== 48'h0 || {r_valid1, r_valid2, r_valid3} !== 3'b000
            || {busy1, busy2, busy3} !== 3'b111) begin
            errors++;
            $display("FAIL midclear_reset_state: got data %h/%h/%h valid %b%b%b busy %b%b%b expected 0 000 111",
                     r_data1, r_data2, r_data3, r_valid1, r_valid2, r_valid3, busy1, busy2, busy3);
        end
        rst = 1'b0;
        count_busy(n1, n2, n3, anyv);
        checks++;
        if (n1 !== 16 || n2 !== 16 || n3 !== 16) begin
            errors++;
            $display("FAIL midclear_busy_len: got %0d/%0d/%0d expected 16", n1, n2, n3);
        end
        checks++;
        if (anyv !== 1'b0) begin
            errors++;
            $display("FAIL midclear_no_valid: got r_valid during sweep, expected none");
        end
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d1, d2, d3, v1, v2, v3, v1b);
            checks++;
            if (d1 !== 16'h0 || d2 !== 16'h0 || d3 !== 16'h0 || {v1, v2, v3} !== 3'b111) begin
                errors++;
                $display("FAIL midclear_read_zero a=%0d: got %h/%h/%h valid %b%b%b expected 0000 valid 111",
                         a, d1, d2, d3, v1, v2, v3);
            end
        end
    endtask

    initial begin
        test_reset;
        test_byte_enable;
        test_back_to_back;
        test_rdw;
        test_clear;
        test_rst_mid_clear;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_sdp_param.md
Name: ram_sdp_param

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one read port, both active in the same cycle.
- Successor to the team's fixed 16x8 single-port cs/wen RAM.
- Adds per-byte write enables, configurable read latency, selectable read-during-write semantics, and a hardware clear engine that zeroes the array after reset or on request.
- Used as the generic storage primitive under register files and buffers.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (forwarded, byte-merged).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- clr  input  1  one-cycle pulse that starts a full-array clear
- busy  output  1  clear engine active; all accesses ignored while high
- w_en  input  1  write request
- w_addr  input  ADDR_W  write address
- w_data  input  DATA_W  write data
- w_be  input  DATA_W/8  byte enables; bit i covers w_data[8i+7:8i]
- r_en  input  1  read request
- r_addr  input  ADDR_W  read address
- r_data  output  DATA_W  read data; holds its last value between reads
- r_valid  output  1  one-cycle pulse marking r_data as new

Behaviour:
- Reset (async assert, sync release):
  - r_data=0, r_valid=0, busy=1, FSM=CLEAR, clr_ptr=0, read pipeline flushed.
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM states CLEAR and IDLE:
  - CLEAR: each edge writes 0 to mem[clr_ptr] and increments clr_ptr.
  - On the edge that writes DEPTH-1: go to IDLE, busy=0. busy is therefore high for exactly DEPTH edges after reset release.
  - IDLE with clr=1: next edge goes to CLEAR, clr_ptr=0, busy=1. clr has priority over any w_en/r_en in the same cycle; those accesses are dropped.
  - clr while in CLEAR: ignored; the sweep is not restarted.
  - rst mid-clear: sweep restarts from 0 after release.
- While busy=1: w_en and r_en are ignored. No array update and no r_valid pulse.
- Write:
  - Accepted in IDLE with w_en=1.
  - At the edge, each byte i with w_be[i]=1 is updated; other bytes keep their value.
  - w_be all zero: no change.
- Read:
  - Accepted in IDLE with r_en=1.
  - RD_LAT=1: r_data is updated at the accept edge; r_valid is high for the following cycle.
  - RD_LAT=2: an extra output register stage; r_data/r_valid appear one edge later.
  - Back-to-back reads sustain one result per cycle at both latencies.
- Read-during-write (r_en & w_en & r_addr==w_addr, same cycle):
  - RDW_MODE=0: r_data returns the pre-write word.
  - RDW_MODE=1: r_data returns the merged word (enabled bytes from w_data, others from the array).
  - Different addresses: independent; no interaction.
- Read pipeline (RD_LAT=2): an entry in flight when clr is accepted still completes with the data captured at its accept edge.
- Address: full 2**ADDR_W range; no out-of-range case, and no wrap logic beyond natural ADDR_W width.

Test Plan:
- Reset release -> busy high for exactly 16 edges, then 0. Read every address 0..15 -> r_data=16'h0000 each, one r_valid per read.
- Write addr 3 = 16'hA5C3 with w_be=2'b11, then write addr 3 = 16'h1F00 with w_be=2'b10. Read addr 3 -> 16'h1FC3.
- RD_LAT=2: reads of addr 0,1,2 on consecutive cycles (preloaded 16'h0011, 16'h0022, 16'h0033) -> r_valid high for 3 consecutive cycles starting 2 edges after first request, data 0011/0022/0033 in order.
- addr 5 holds 16'h1234. Same-cycle write 16'hBEEF (w_be=2'b01) and read of addr 5 -> RDW_MODE=0 returns 16'h1234, RDW_MODE=1 returns 16'h12EF. A following read returns 16'h12EF in both modes.
- Preload addr 7 = 16'h7777. Pulse clr together with a write 16'hFFFF to addr 7 -> the write is dropped; busy high for 16 cycles. A read during busy gives no r_valid. A read after busy falls returns 16'h0000.
- Assert rst at clear step 8, hold 2 cycles, release -> busy high for a full 16 edges again. r_valid stays 0 throughout. All words read 0 afterwards.
